controlador_de_interrupcao: RTL

- Interrupt controller on the requesting side of the CPU's `inta` handshake.
- Captures rising edges on peripheral request lines into sticky pending bits, filters them with a software mask, and picks the highest-priority source.
- At a CPU instruction boundary it drives a one-cycle `inta` pulse. The program counter uses that pulse to save its return address and jump to 0.
- It then holds off further interrupts until the handler executes `reti`, so there is no nesting.

---
 rtl/controlador_de_interrupcao_pkg.sv | 22 ++
 rtl/controlador_de_interrupcao_if.sv | 47 ++++
 rtl/controlador_de_interrupcao_codificador_prioridade.sv | 32 +++
 rtl/controlador_de_interrupcao.sv | 127 ++++++++++++
 4 files changed

// File: rtl/controlador_de_interrupcao_pkg.sv
// ----------------------------------------------------------------------------
// interrupcao_pkg
// Shared definitions for the interrupt controller slice:
//   - estado_t         : acknowledge FSM states (IDLE / ACK / SERVICE)
//   - NUM_IRQ_DEFAULT  : default number of peripheral request lines
//   - ID_W_DEFAULT     : default width of the source index
// ----------------------------------------------------------------------------
package interrupcao_pkg;

  localparam int NUM_IRQ_DEFAULT = 8;
  localparam int ID_W_DEFAULT    = 3;

  // IDLE    : free to acknowledge a new request
  // ACK     : inta is high this cycle
  // SERVICE : handler running, waiting for reti
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    SERVICE = 2'd2
  } estado_t;

endpackage

// File: rtl/controlador_de_interrupcao_if.sv
// ----------------------------------------------------------------------------
// controlador_de_interrupcao_if
// Bundles the request/CPU-facing signals of the interrupt controller.
//   master : the environment (peripherals + CPU) driving requests, control
//            strobes and register writes; observes acknowledge and status
//   slave  : the controller itself
// Signals:
//   irq, int_enable, instr_boundary, reti, mask_we, mask_in, clr_we, clr_in
//     -> into the controller
//   inta, irq_id, in_service, pending, mask
//     -> out of the controller
// ----------------------------------------------------------------------------
interface controlador_de_interrupcao_if
  import interrupcao_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int ID_W    = ID_W_DEFAULT
) ();

  logic [NUM_IRQ-1:0] irq;
  logic               int_enable;
  logic               instr_boundary;
  logic               reti;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_in;
  logic               clr_we;
  logic [NUM_IRQ-1:0] clr_in;

  logic               inta;
  logic [ID_W-1:0]    irq_id;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq, int_enable, instr_boundary, reti,
           mask_we, mask_in, clr_we, clr_in,
    input  inta, irq_id, in_service, pending, mask
  );

  modport slave (
    input  irq, int_enable, instr_boundary, reti,
           mask_we, mask_in, clr_we, clr_in,
    output inta, irq_id, in_service, pending, mask
  );

endinterface

// File: rtl/controlador_de_interrupcao_codificador_prioridade.sv
// ----------------------------------------------------------------------------
// codificador_prioridade
// Purely combinational fixed-priority encoder; the lowest set index wins.
// Ports:
//   req   in  NUM_IRQ  candidate request vector
//   valid out 1        at least one bit of req is set
//   idx   out ID_W     index of the lowest set bit (0 when req is empty)
// ----------------------------------------------------------------------------
module codificador_prioridade
  import interrupcao_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int ID_W    = ID_W_DEFAULT
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Scanning from the top down lets the lowest set bit overwrite any
  // higher one, which gives lowest-index-first priority.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/controlador_de_interrupcao.sv
// ----------------------------------------------------------------------------
// controlador_de_interrupcao
// Non-nesting interrupt controller. Rising edges on irq become sticky
// pending bits, filtered by a software mask; at an instruction boundary with
// interrupts enabled the lowest-index candidate is acknowledged with a
// one-cycle registered inta pulse. Further acknowledges are held off until
// the handler retires with reti.
// Ports:
//   clk    in  clock, all state changes on posedge
//   reset  in  synchronous, active-high, clears all state
//   bus    slave modport of controlador_de_interrupcao_if:
//          in : irq, int_enable, instr_boundary, reti, mask_we, mask_in,
//               clr_we, clr_in
//          out: inta, irq_id, in_service, pending, mask
// ID_W must satisfy 2**ID_W >= NUM_IRQ.
// ----------------------------------------------------------------------------
module controlador_de_interrupcao
  import interrupcao_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int ID_W    = ID_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  controlador_de_interrupcao_if.slave   bus
);

  estado_t            state_q,      state_d;
  logic [NUM_IRQ-1:0] irq_d_q,      irq_d_d;
  logic [NUM_IRQ-1:0] pending_q,    pending_d;
  logic [NUM_IRQ-1:0] mask_q,       mask_d;
  logic [ID_W-1:0]    irq_id_q,     irq_id_d;
  logic               inta_q,       inta_d;
  logic               in_service_q, in_service_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] ack_onehot;
  logic [NUM_IRQ-1:0] clear_vec;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_idx;

  // Decisions use the mask as it stands this cycle; a write lands next cycle.
  assign cand = pending_q & mask_q;

  codificador_prioridade #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_codificador (
    .req   (cand),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  // Acknowledge FSM. inta is registered, so it rises the cycle after the
  // decision and stays high for the whole ACK cycle.
  always_comb begin
    state_d      = state_q;
    inta_d       = 1'b0;
    in_service_d = in_service_q;
    irq_id_d     = irq_id_q;
    ack_onehot   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.int_enable && bus.instr_boundary && cand_valid) begin
          state_d    = ACK;
          inta_d     = 1'b1;
          irq_id_d   = cand_idx;
          ack_onehot = NUM_IRQ'(1) << cand_idx;
        end
      end
      ACK: begin
        state_d      = SERVICE;
        in_service_d = 1'b1;
      end
      SERVICE: begin
        if (bus.reti) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Edge capture, pending and mask bookkeeping. A fresh edge is ORed in after
  // the clear so that a simultaneous set and clear keeps the new event.
  always_comb begin
    rise      = bus.irq & ~irq_d_q;
    irq_d_d   = bus.irq;
    clear_vec = (bus.clr_we ? bus.clr_in : '0) | ack_onehot;
    pending_d = (pending_q & ~clear_vec) | rise;
    mask_d    = bus.mask_we ? bus.mask_in : mask_q;
  end

  // State register. irq_d clearing to 0 makes a line already high at reset
  // release register as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_d_q      <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      irq_id_q     <= '0;
      inta_q       <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_d_q      <= irq_d_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_id_q     <= irq_id_d;
      inta_q       <= inta_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.inta       = inta_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;

endmodule
